// File: rtl/pwm_duty_ramp_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_duty_ramp_ctrl_if
//  Brief    : Target-duty request channel (valid/ready) for pwm_duty_ramp_ctrl.
//             The master offers a target duty, step and divider; the slave
//             (the ramp controller) returns ready.
//  Revision : 1.0 - initial release
// ============================================================================
interface pwm_duty_ramp_ctrl_if #(
    parameter int DUTY_W = 7,
    parameter int DIV_W  = 16
);
    logic              io_tgt_valid;
    logic              io_tgt_ready;
    logic [DUTY_W-1:0] io_tgt_duty;
    logic [DUTY_W-1:0] io_step;
    logic [DIV_W-1:0]  io_div;

    modport master (
        output io_tgt_valid,
        output io_tgt_duty,
        output io_step,
        output io_div,
        input  io_tgt_ready
    );

    modport slave (
        input  io_tgt_valid,
        input  io_tgt_duty,
        input  io_step,
        input  io_div,
        output io_tgt_ready
    );
endinterface
`default_nettype wire

// File: rtl/pwm_duty_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_duty_ramp_ctrl
//  Brief    : Duty-cycle sequencer for the ModPWMCore PWM core. Accepts a
//             target duty and slews the applied duty toward it by a
//             programmable step, changing it only on PWM period boundaries.
//  Options  : PWM_RAMP_RETARGET_EN - accept a new target while ramping.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_duty_ramp_ctrl #(
    parameter int DUTY_W = 7,
    parameter int PERIOD = 100,
    parameter int DIV_W  = 16
) (
    input  wire logic              clock,
    input  wire logic              reset,          // synchronous, active-low
    pwm_duty_ramp_ctrl_if.slave    tgt_if,
    output logic [DUTY_W-1:0]      io_dutyCycle,
    output logic                   io_period_start,
    output logic                   io_busy,
    output logic                   io_done
);

    localparam int                c_CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(PERIOD - 1);
    localparam logic [DUTY_W:0]   c_PERIOD_X = (DUTY_W + 1)'(PERIOD);
    localparam logic [DUTY_W-1:0] c_PERIOD_D = DUTY_W'(PERIOD);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               run_q;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               period_start_q;
    logic [DUTY_W-1:0]  duty_q, duty_d;
    logic [DUTY_W-1:0]  tgt_q, tgt_d;
    logic [DUTY_W-1:0]  step_q, step_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   divcnt_q, divcnt_d;

    logic               w_boundary;
    logic               w_ready;
    logic [DUTY_W-1:0]  w_req_tgt;
    logic [DUTY_W-1:0]  w_req_step;
    logic [DIV_W-1:0]   w_req_div;
    logic               w_up;
    logic [DUTY_W:0]    w_dist;
    logic [DUTY_W-1:0]  w_delta;
    logic [DUTY_W-1:0]  w_duty_step;

    // Period counter next value; it holds at 0 for the first cycle after
    // reset release so that cycle is the first period start.
    always_comb begin
        cnt_d = '0;
        if (run_q && (cnt_q != c_CNT_LAST)) begin
            cnt_d = cnt_q + c_CNT_W'(1);
        end
    end

    assign w_boundary = (cnt_d == '0);

    // Period counter and registered period-start flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            run_q          <= 1'b0;
            cnt_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            run_q          <= 1'b1;
            cnt_q          <= cnt_d;
            period_start_q <= w_boundary;
        end
    end

    // Request normalisation: saturate target, treat zero step/divider as 1.
    assign w_req_tgt  = ({1'b0, tgt_if.io_tgt_duty} > c_PERIOD_X) ? c_PERIOD_D
                                                                  : tgt_if.io_tgt_duty;
    assign w_req_step = (tgt_if.io_step == '0) ? DUTY_W'(1) : tgt_if.io_step;
    assign w_req_div  = (tgt_if.io_div == '0)  ? DIV_W'(1)  : tgt_if.io_div;

    // Next ramp value: move by min(step, distance) so the target is never overshot.
    assign w_up        = (tgt_q > duty_q);
    assign w_dist      = w_up ? ({1'b0, tgt_q} - {1'b0, duty_q})
                              : ({1'b0, duty_q} - {1'b0, tgt_q});
    assign w_delta     = ({1'b0, step_q} < w_dist) ? step_q : w_dist[DUTY_W-1:0];
    assign w_duty_step = w_up ? (duty_q + w_delta) : (duty_q - w_delta);

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state, handshake and ramp datapath decisions.
    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        tgt_d    = tgt_q;
        step_d   = step_q;
        div_d    = div_q;
        divcnt_d = divcnt_q;
        w_ready  = 1'b0;
        io_busy  = 1'b0;
        io_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (tgt_if.io_tgt_valid) begin
                    tgt_d    = w_req_tgt;
                    step_d   = w_req_step;
                    div_d    = w_req_div;
                    divcnt_d = w_req_div - DIV_W'(1);
                    state_d  = (w_req_tgt == duty_q) ? ST_DONE : ST_RAMP;
                end
            end
            ST_RAMP: begin
                io_busy = 1'b1;
`ifdef PWM_RAMP_RETARGET_EN
                w_ready = 1'b1;
                // A new request overrides any update due this cycle.
                if (tgt_if.io_tgt_valid) begin
                    tgt_d    = w_req_tgt;
                    step_d   = w_req_step;
                    div_d    = w_req_div;
                    divcnt_d = w_req_div - DIV_W'(1);
                    if (w_req_tgt == duty_q) begin
                        state_d = ST_DONE;
                    end
                end else
`endif
                if (w_boundary) begin
                    if (divcnt_q != '0) begin
                        divcnt_d = divcnt_q - DIV_W'(1);
                    end else begin
                        divcnt_d = div_q - DIV_W'(1);
                        duty_d   = w_duty_step;
                        if (w_duty_step == tgt_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                io_done = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ramp datapath registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            duty_q   <= '0;
            tgt_q    <= '0;
            step_q   <= '0;
            div_q    <= '0;
            divcnt_q <= '0;
        end else begin
            duty_q   <= duty_d;
            tgt_q    <= tgt_d;
            step_q   <= step_d;
            div_q    <= div_d;
            divcnt_q <= divcnt_d;
        end
    end

    assign tgt_if.io_tgt_ready = w_ready;
    assign io_dutyCycle        = duty_q;
    assign io_period_start     = period_start_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_duty_ramp_ctrl
//  Brief    : Directed self-checking bench for pwm_duty_ramp_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_ramp_ctrl;
    localparam int DUTY_W = 7;
    localparam int DIV_W  = 16;
    localparam int PERIOD = 100;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    pwm_duty_ramp_ctrl_if #(.DUTY_W(DUTY_W), .DIV_W(DIV_W)) tgt_if ();

    logic [DUTY_W-1:0] duty;
    logic              ps;
    logic              busy;
    logic              done;

    pwm_duty_ramp_ctrl #(.DUTY_W(DUTY_W), .PERIOD(PERIOD), .DIV_W(DIV_W)) u_dut (
        .clock           (clock),
        .reset           (reset),
        .tgt_if          (tgt_if),
        .io_dutyCycle    (duty),
        .io_period_start (ps),
        .io_busy         (busy),
        .io_done         (done)
    );

    int n_cmp = 0;
    int n_err = 0;
    int t     = 0;
    int dq[$];
    int dt[$];
    int xfer_duty;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        t++;
    endtask

    // Offer a request and hold it until it is accepted (bounded).
    task automatic send(input int tg, input int st, input int dv, output int stall);
        int got;
        int r;
        got = 0;
        stall = 0;
        tgt_if.io_tgt_valid = 1'b1;
        tgt_if.io_tgt_duty  = DUTY_W'(tg);
        tgt_if.io_step      = DUTY_W'(st);
        tgt_if.io_div       = DIV_W'(dv);
        for (int i = 0; i < 2000 && got == 0; i++) begin
            r = int'(tgt_if.io_tgt_ready);
            xfer_duty = int'(duty);
            step();
            if (r != 0) got = 1;
            else stall++;
        end
        tgt_if.io_tgt_valid = 1'b0;
        // junk outside a transfer must be ignored
        tgt_if.io_tgt_duty  = DUTY_W'(85);
        tgt_if.io_step      = DUTY_W'(3);
        tgt_if.io_div       = DIV_W'(7);
        chk("xfer_accepted", got, 1);
    endtask

    // Record every applied-duty change until the done pulse (bounded).
    task automatic watch(input int budget);
        int prev;
        int seen;
        seen = 0;
        dq.delete();
        dt.delete();
        prev = int'(duty);
        for (int i = 0; i < budget && seen == 0; i++) begin
            step();
            if (int'(duty) != prev) begin
                dq.push_back(int'(duty));
                dt.push_back(t);
                chk("upd_on_period_start", int'(ps), 1);
                prev = int'(duty);
            end
            if (done) begin
                seen = 1;
                chk("busy_low_at_done", int'(busy), 0);
            end
        end
        chk("done_seen", seen, 1);
        if (seen != 0) begin
            step();
            chk("done_one_cycle", int'(done), 0);
            chk("ready_after_done", int'(tgt_if.io_tgt_ready), 1);
        end
    endtask

    task automatic chk_seq(input string tag, input int n,
                           input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({tag, "_len"}, dq.size(), n);
        for (int i = 0; i < n && i < 4; i++) begin
            chk($sformatf("%s_v%0d", tag, i), (i < dq.size()) ? dq[i] : -1, e[i]);
        end
    endtask

    task automatic chk_gap(input string tag, input int gap);
        int bad;
        bad = 0;
        for (int i = 1; i < dt.size(); i++) begin
            if (dt[i] - dt[i-1] != gap) bad++;
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        int st;
        int bad;
        int reached;

        tgt_if.io_tgt_valid = 1'b0;
        tgt_if.io_tgt_duty  = '0;
        tgt_if.io_step      = '0;
        tgt_if.io_div       = '0;

        // 1: reset held for 3 edges
        repeat (3) @(posedge clock);
        #1;
        chk("rst_duty",  int'(duty), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_done",  int'(done), 0);
        chk("rst_ps",    int'(ps),   0);
        chk("rst_ready", int'(tgt_if.io_tgt_ready), 1);
        reset = 1'b1;
        step();
        t = 0;
        chk("ps_first_cycle", int'(ps), 1);
        bad = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (int'(ps) != ((t % 100 == 0) ? 1 : 0)) bad++;
        end
        chk("ps_every_100", bad, 0);
        chk("ps_at_100", int'(ps), 1);

        // 2: 0 -> 40, step 10, every boundary (transfer at t=101)
        send(40, 10, 1, st);
        chk("t2_no_stall", st, 0);
        watch(600);
        chk_seq("t2", 4, 10, 20, 30, 40);
        chk("t2_first_at", (dt.size() > 0) ? dt[0] : -1, 200);
        chk_gap("t2_gap", 100);

        // 3: 40 -> 5, step 10, every 2nd boundary (transfer at t=502)
        send(5, 10, 2, st);
        watch(1500);
        chk_seq("t3", 4, 30, 20, 10, 5);
        chk("t3_first_at", (dt.size() > 0) ? dt[0] : -1, 700);
        chk_gap("t3_gap", 200);

        // 4: 120 saturates to 100; step=0 and div=0 act as 1
        send(120, 0, 0, st);
        watch(9800);
        chk("t4_len", dq.size(), 95);
        chk("t4_first", (dq.size() > 0) ? dq[0] : -1, 6);
        chk("t4_last", (dq.size() > 0) ? dq[dq.size()-1] : -1, 100);
        chk_gap("t4_gap", 100);

        // 4: equal target -> immediate done, no duty change
        send(100, 3, 3, st);
        chk("eq_done", int'(done), 1);
        chk("eq_duty", int'(duty), 100);
        chk("eq_busy", int'(busy), 0);
        step();
        chk("eq_done_off", int'(done), 0);
        chk("eq_duty_hold", int'(duty), 100);
        send(127, 5, 5, st);
        chk("sat_eq_done", int'(done), 1);
        chk("sat_eq_duty", int'(duty), 100);
        step();

        // down to zero without wrapping below 0
        send(0, 50, 0, st);
        watch(400);
        chk_seq("to0", 2, 50, 0, 0, 0);

        // 5: reset mid-ramp at duty 30
        send(60, 30, 1, st);
        reached = 0;
        for (int i = 0; i < 300 && reached == 0; i++) begin
            step();
            if (int'(duty) == 30) reached = 1;
        end
        chk("t5_reached30", reached, 1);
        chk("t5_busy_before", int'(busy), 1);
        reset = 1'b0;
        step();
        chk("t5_duty0", int'(duty), 0);
        chk("t5_busy0", int'(busy), 0);
        chk("t5_done0", int'(done), 0);
        reset = 1'b1;
        step();
        t = 0;
        chk("t5_ps_restart", int'(ps), 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) bad++;
        end
        chk("t5_no_done", bad, 0);

        // 6: retarget request while ramping 0 -> 60
        send(60, 10, 1, st);
        reached = 0;
        for (int i = 0; i < 300 && reached == 0; i++) begin
            step();
            if (int'(duty) == 30) reached = 1;
        end
        chk("t6_reached30", reached, 1);
        send(20, 10, 1, st);
`ifdef PWM_RAMP_RETARGET_EN
        chk("t6_no_stall", st, 0);
        chk("t6_duty_at_xfer", xfer_duty, 30);
        watch(300);
        chk_seq("t6", 1, 20, 0, 0, 0);
`else
        chk("t6_stalled", (st > 0) ? 1 : 0, 1);
        chk("t6_duty_at_xfer", xfer_duty, 60);
        watch(600);
        chk_seq("t6", 4, 50, 40, 30, 20);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
